// File: rtl/multicycle_stage_ctrl_if.sv
// Control bundle between the multi-cycle sequencer and the datapath/memory side.
// master = sequencer, slave = datapath stage registers and memory port.
interface multicycle_stage_ctrl_if #(
  parameter int CNT_W = 32
);
  logic             run;
  logic             op_load;
  logic             op_store;
  logic             op_branch;
  logic             op_halt;
  logic             mem_ack;
  logic             mem_req;
  logic             mem_we;
  logic             pc_en;
  logic             ir_en;
  logic             dec_en;
  logic             ex_en;
  logic             mem_en;
  logic             wb_en;
  logic [2:0]       state;
  logic             halted;
  logic             timeout_err;
  logic [CNT_W-1:0] cycle_cnt;
  logic [CNT_W-1:0] instr_cnt;

  modport master (
    input  run, op_load, op_store, op_branch, op_halt, mem_ack,
    output mem_req, mem_we, pc_en, ir_en, dec_en, ex_en, mem_en, wb_en,
    output state, halted, timeout_err, cycle_cnt, instr_cnt
  );

  modport slave (
    output run, op_load, op_store, op_branch, op_halt, mem_ack,
    input  mem_req, mem_we, pc_en, ir_en, dec_en, ex_en, mem_en, wb_en,
    input  state, halted, timeout_err, cycle_cnt, instr_cnt
  );
endinterface

// File: rtl/multicycle_stage_ctrl.sv
// IF/ID/EX/MEM/WB sequencer for the multi-cycle CPU: stage-register enable pulses,
// memory request/ack handshake with timeout, cycle and retired-instruction counters.
module multicycle_stage_ctrl #(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  multicycle_stage_ctrl_if.master bus
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_IF   = 3'd1,
    S_ID   = 3'd2,
    S_EX   = 3'd3,
    S_MEM  = 3'd4,
    S_WB   = 3'd5,
    S_HALT = 3'd6,
    S_ERR  = 3'd7
  } state_t;

  localparam int WAIT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;

  state_t           state_q, state_nxt;
  logic [WAIT_W-1:0] wait_cnt;
  logic             cls_ld, cls_st, cls_br;
  logic             cls_ld_nxt, cls_st_nxt, cls_br_nxt;
  logic             retire;
  logic             wait_last;
  logic [CNT_W-1:0] cycle_cnt, instr_cnt;

  assign wait_last = (wait_cnt == WAIT_W'(MEM_TIMEOUT - 1));

  always_comb begin
    state_nxt   = state_q;
    cls_ld_nxt  = cls_ld;
    cls_st_nxt  = cls_st;
    cls_br_nxt  = cls_br;
    retire      = 1'b0;
    bus.mem_req = 1'b0;
    bus.mem_we  = 1'b0;
    bus.pc_en   = 1'b0;
    bus.ir_en   = 1'b0;
    bus.dec_en  = 1'b0;
    bus.ex_en   = 1'b0;
    bus.mem_en  = 1'b0;
    bus.wb_en   = 1'b0;
    unique case (state_q)
      S_IDLE: if (bus.run) state_nxt = S_IF;
      S_IF: begin
        bus.mem_req = 1'b1;
        if (bus.mem_ack) begin
          bus.ir_en = 1'b1;
          bus.pc_en = 1'b1;
          state_nxt = S_ID;
        end else if (wait_last) begin
          state_nxt = S_ERR;
        end
      end
      S_ID: begin
        bus.dec_en = 1'b1;
        // one-hot class with halt > branch > load > store > ALU priority
        cls_br_nxt = bus.op_branch & ~bus.op_halt;
        cls_ld_nxt = bus.op_load  & ~bus.op_halt & ~bus.op_branch;
        cls_st_nxt = bus.op_store & ~bus.op_halt & ~bus.op_branch & ~bus.op_load;
        state_nxt  = bus.op_halt ? S_HALT : S_EX;
      end
      S_EX: begin
        bus.ex_en = 1'b1;
        if (cls_br) begin
          bus.pc_en = 1'b1;
          retire    = 1'b1;
        end else if (cls_ld || cls_st) begin
          state_nxt = S_MEM;
        end else begin
          state_nxt = S_WB;
        end
      end
      S_MEM: begin
        bus.mem_req = 1'b1;
        bus.mem_we  = cls_st;
        if (bus.mem_ack) begin
          bus.mem_en = 1'b1;
          if (cls_ld) state_nxt = S_WB;
          else        retire    = 1'b1;
        end else if (wait_last) begin
          state_nxt = S_ERR;
        end
      end
      S_WB: begin
        bus.wb_en = 1'b1;
        retire    = 1'b1;
      end
      S_HALT: state_nxt = S_HALT;
      S_ERR:  state_nxt = S_ERR;
    endcase
    if (retire) state_nxt = bus.run ? S_IF : S_IDLE;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      cls_ld  <= 1'b0;
      cls_st  <= 1'b0;
      cls_br  <= 1'b0;
    end else begin
      state_q <= state_nxt;
      cls_ld  <= cls_ld_nxt;
      cls_st  <= cls_st_nxt;
      cls_br  <= cls_br_nxt;
    end
  end

  // any state change restarts the wait window, so entry into IF/MEM always sees 0
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      wait_cnt <= '0;
    else if (state_nxt != state_q)
      wait_cnt <= '0;
    else if (state_q == S_IF || state_q == S_MEM)
      wait_cnt <= wait_cnt + 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cycle_cnt <= '0;
      instr_cnt <= '0;
    end else begin
      if (state_q != S_IDLE && state_q != S_HALT && state_q != S_ERR)
        cycle_cnt <= cycle_cnt + 1'b1;
      if (retire)
        instr_cnt <= instr_cnt + 1'b1;
    end
  end

  assign bus.state       = state_q;
  assign bus.halted      = (state_q == S_HALT);
  assign bus.timeout_err = (state_q == S_ERR);
  assign bus.cycle_cnt   = cycle_cnt;
  assign bus.instr_cnt   = instr_cnt;

endmodule

// File: tb/tb_multicycle_stage_ctrl.sv
// Directed bench for multicycle_stage_ctrl; a second 2-bit-counter instance
// shadows the main one to exercise counter wrap.
module tb_multicycle_stage_ctrl;
  logic clk = 1'b0;
  logic rst;
  int   n_chk = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  multicycle_stage_ctrl_if #(.CNT_W(32)) bus ();
  multicycle_stage_ctrl_if #(.CNT_W(2))  sbus ();

  multicycle_stage_ctrl #(.MEM_TIMEOUT(16), .CNT_W(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  multicycle_stage_ctrl #(.MEM_TIMEOUT(16), .CNT_W(2)) dut_small (
    .clk (clk),
    .rst (rst),
    .bus (sbus)
  );

  assign sbus.run       = bus.run;
  assign sbus.op_load   = bus.op_load;
  assign sbus.op_store  = bus.op_store;
  assign sbus.op_branch = bus.op_branch;
  assign sbus.op_halt   = bus.op_halt;
  assign sbus.mem_ack   = bus.mem_ack;

  // pc, ir, dec, ex, mem, wb
  wire [5:0] en  = {bus.pc_en, bus.ir_en, bus.dec_en, bus.ex_en, bus.mem_en, bus.wb_en};
  wire [3:0] flg = {bus.mem_req, bus.mem_we, bus.halted, bus.timeout_err};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #2;
  endtask

  initial begin
    rst = 1'b0;
    bus.run = 0; bus.op_load = 0; bus.op_store = 0; bus.op_branch = 0;
    bus.op_halt = 0; bus.mem_ack = 0;
    #3;
    chk("rst_state", 32'(bus.state), 0);
    chk("rst_en", 32'(en), 0);
    chk("rst_flags", 32'(flg), 0);
    chk("rst_cycle", bus.cycle_cnt, 0);
    chk("rst_instr", bus.instr_cnt, 0);
    tick;
    rst = 1'b1; bus.run = 1;
    #1 chk("idle_state", 32'(bus.state), 0);

    // ALU, ack on first IF cycle
    tick; bus.mem_ack = 1;
    #1 chk("alu_if_state", 32'(bus.state), 1);
    chk("alu_if_en", 32'(en), 32'b110000);
    chk("alu_if_flags", 32'(flg), 32'b1000);
    tick; bus.mem_ack = 0;
    #1 chk("alu_id_state", 32'(bus.state), 2);
    chk("alu_id_en", 32'(en), 32'b001000);
    tick;
    #1 chk("alu_ex_state", 32'(bus.state), 3);
    chk("alu_ex_en", 32'(en), 32'b000100);
    tick;
    #1 chk("alu_wb_state", 32'(bus.state), 5);
    chk("alu_wb_en", 32'(en), 32'b000001);
    tick;
    #1 chk("alu_if2_state", 32'(bus.state), 1);
    chk("alu_instr", bus.instr_cnt, 1);
    chk("alu_cycle", bus.cycle_cnt, 4);
    chk("wrap_cycle_4", 32'(sbus.cycle_cnt), 0);
    chk("small_instr_1", 32'(sbus.instr_cnt), 1);

    // load, ack delayed 3 cycles in MEM
    bus.mem_ack = 1;
    tick; bus.mem_ack = 0; bus.op_load = 1;
    #1 chk("ld_id_en", 32'(en), 32'b001000);
    tick; bus.op_load = 0;
    #1 chk("ld_ex_en", 32'(en), 32'b000100);
    tick;
    for (int i = 0; i < 3; i++) begin
      #1 chk("ld_mem_wait_state", 32'(bus.state), 4);
      chk("ld_mem_wait_flags", 32'(flg), 32'b1000);
      chk("ld_mem_wait_en", 32'(en), 0);
      tick;
    end
    bus.mem_ack = 1;
    #1 chk("ld_mem_ack_flags", 32'(flg), 32'b1000);
    chk("ld_mem_ack_en", 32'(en), 32'b000010);
    tick; bus.mem_ack = 0;
    #1 chk("ld_wb_state", 32'(bus.state), 5);
    chk("ld_wb_en", 32'(en), 32'b000001);
    tick;
    #1 chk("ld_if_state", 32'(bus.state), 1);
    chk("ld_instr", bus.instr_cnt, 2);
    chk("ld_cycle", bus.cycle_cnt, 12);

    // store, ack immediately in MEM
    bus.mem_ack = 1;
    tick; bus.mem_ack = 0; bus.op_store = 1;
    tick; bus.op_store = 0;
    #1 chk("st_ex_state", 32'(bus.state), 3);
    tick; bus.mem_ack = 1;
    #1 chk("st_mem_state", 32'(bus.state), 4);
    chk("st_mem_flags", 32'(flg), 32'b1100);
    chk("st_mem_en", 32'(en), 32'b000010);
    tick; bus.mem_ack = 0;
    #1 chk("st_ret_state", 32'(bus.state), 1);
    chk("st_instr", bus.instr_cnt, 3);
    chk("st_cycle", bus.cycle_cnt, 16);

    // branch outranks load in ID
    bus.mem_ack = 1;
    tick; bus.mem_ack = 0; bus.op_branch = 1; bus.op_load = 1;
    tick; bus.op_branch = 0; bus.op_load = 0;
    #1 chk("br_ex_en", 32'(en), 32'b100100);
    tick;
    #1 chk("br_ret_state", 32'(bus.state), 1);
    chk("br_instr", bus.instr_cnt, 4);
    chk("br_cycle", bus.cycle_cnt, 19);
    chk("wrap_instr_4", 32'(sbus.instr_cnt), 0);
    chk("wrap_cycle_19", 32'(sbus.cycle_cnt), 3);

    // run dropped mid-instruction: ALU completes then IDLE
    bus.mem_ack = 1;
    tick; bus.mem_ack = 0; bus.run = 0;
    tick;
    tick;
    #1 chk("rundrop_wb_state", 32'(bus.state), 5);
    tick;
    #1 chk("rundrop_idle_state", 32'(bus.state), 0);
    chk("rundrop_instr", bus.instr_cnt, 5);
    tick;
    #1 chk("idle_cycle_frozen", bus.cycle_cnt, 23);
    bus.run = 1;
    tick;

    // ack on the 16th (last allowed) IF cycle
    for (int i = 0; i < 15; i++) begin
      #1 chk("late_if_state", 32'(bus.state), 1);
      tick;
    end
    bus.mem_ack = 1;
    #1 chk("late_ack_en", 32'(en), 32'b110000);
    tick; bus.mem_ack = 0;
    #1 chk("late_id_state", 32'(bus.state), 2);
    chk("late_no_err", 32'(bus.timeout_err), 0);
    tick; tick; tick;
    #1 chk("late_if_state2", 32'(bus.state), 1);
    chk("late_cycle", bus.cycle_cnt, 42);
    chk("late_instr", bus.instr_cnt, 6);

    // halt + load in ID -> HALT, absorbing
    bus.mem_ack = 1;
    tick; bus.mem_ack = 0; bus.op_halt = 1; bus.op_load = 1;
    #1 chk("halt_id_en", 32'(en), 32'b001000);
    tick; bus.op_halt = 0; bus.op_load = 0;
    #1 chk("halt_state", 32'(bus.state), 6);
    chk("halt_flags", 32'(flg), 32'b0010);
    chk("halt_en", 32'(en), 0);
    for (int i = 0; i < 4; i++) begin
      bus.run = i[0]; bus.mem_ack = ~i[0];
      tick;
      #1 chk("halt_stay_state", 32'(bus.state), 6);
      chk("halt_stay_en", 32'(en), 0);
      chk("halt_cycle", bus.cycle_cnt, 44);
      chk("halt_instr", bus.instr_cnt, 6);
    end

    // no ack: IF for exactly 16 cycles, then ERR
    rst = 1'b0; bus.mem_ack = 0;
    #1 chk("rst_from_halt", 32'(bus.state), 0);
    rst = 1'b1; bus.run = 1;
    tick;
    for (int i = 0; i < 16; i++) begin
      #1 chk("to_if_state", 32'(bus.state), 1);
      tick;
    end
    #1 chk("to_err_state", 32'(bus.state), 7);
    chk("to_err_flags", 32'(flg), 32'b0001);
    chk("to_cycle", bus.cycle_cnt, 16);
    bus.mem_ack = 1;
    tick; bus.mem_ack = 0;
    #1 chk("err_stay_state", 32'(bus.state), 7);
    chk("err_cycle", bus.cycle_cnt, 16);

    // async reset while MEM is requesting
    rst = 1'b0;
    #1 rst = 1'b1;
    tick; bus.mem_ack = 1;
    tick; bus.mem_ack = 0; bus.op_load = 1;
    tick; bus.op_load = 0;
    tick;
    #1 chk("arst_mem_req", 32'(bus.mem_req), 1);
    #1 rst = 1'b0;
    #1 chk("arst_req_drop", 32'(bus.mem_req), 0);
    chk("arst_state", 32'(bus.state), 0);
    chk("arst_en", 32'(en), 0);
    chk("arst_flags", 32'(flg), 0);
    chk("arst_cycle", bus.cycle_cnt, 0);
    rst = 1'b1;
    tick;
    #1 chk("arst_release_if", 32'(bus.state), 1);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
